// File: rtl/data_mem_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : data_mem_ctrl
// Brief    : Multi-cycle big-endian byte RAM controller with busy/done/err.
// Revision : 1.0
// ============================================================================
module data_mem_ctrl #(
   parameter int DEPTH   = 1024,
   parameter int LATENCY = 2
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        MemRead,
   input  logic        MemWrite,
   input  logic [3:0]  XferSize,
   input  logic [63:0] address,
   input  logic [63:0] WriteData,
   output logic [63:0] ReadData,
   output logic        busy,
   output logic        done,
   output logic        err
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = $clog2(LATENCY + 1);
   localparam logic [CW-1:0] c_cnt_init = CW'(LATENCY);
   localparam logic [64:0]   c_depth    = 65'(DEPTH);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_WAIT = 2'd1,
      S_RESP = 2'd2
   } state_t;

   state_t        r_state;
   state_t        w_state_nxt;
   logic [CW-1:0] r_cnt;
   logic          r_rd;
   logic          r_wr;
   logic          r_err;
   logic [3:0]    r_size;
   logic [63:0]   r_addr;
   logic [63:0]   r_wdata;
   logic [63:0]   r_rdata;
   logic [7:0]    r_mem [DEPTH];

   logic          w_accept;
   logic          w_fire;
   logic          w_size_ok;
   logic          w_align_ok;
   logic          w_range_ok;
   logic          w_reject;
   logic [64:0]   w_end;
   logic [63:0]   w_rdata;
   logic [7:0]    w_wbyte [8];

   assign w_accept = (r_state == S_IDLE) && (MemRead || MemWrite);
   assign w_fire   = (r_state == S_WAIT) && (r_cnt == CW'(1));

   always_comb begin
      w_size_ok = 1'b0;
      case (r_size)
         4'd1, 4'd2, 4'd4, 4'd8: w_size_ok = 1'b1;
         default:                w_size_ok = 1'b0;
      endcase
   end

   // Size 8 wraps to 3'b000, so size-1 gives the 3'b111 alignment mask.
   assign w_align_ok = (r_addr[2:0] & (r_size[2:0] - 3'd1)) == 3'd0;
   assign w_end      = {1'b0, r_addr} + {61'd0, r_size};
   assign w_range_ok = (w_end <= c_depth);
   assign w_reject   = (r_rd && r_wr) || !w_size_ok || !w_align_ok || !w_range_ok;

   always_comb begin
      w_rdata = '0;
      for (int i = 0; i < 8; i++) begin
         if (i < int'(r_size)) begin
            w_rdata = {w_rdata[55:0], r_mem[r_addr[AW-1:0] + AW'(i)]};
         end
      end
   end

   always_comb begin
      for (int i = 0; i < 8; i++) begin
         w_wbyte[i] = 8'(r_wdata >> {3'(r_size - 4'd1 - 4'(i)), 3'b000});
      end
   end

   // RAM contents survive reset; writes only happen on a good WAIT completion.
   always_ff @(posedge clk) begin
      if (w_fire && r_wr && !w_reject) begin
         for (int i = 0; i < 8; i++) begin
            if (i < int'(r_size)) begin
               r_mem[r_addr[AW-1:0] + AW'(i)] <= w_wbyte[i];
            end
         end
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      busy        = 1'b0;
      done        = 1'b0;
      err         = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (MemRead || MemWrite) w_state_nxt = S_WAIT;
         end
         S_WAIT: begin
            busy = 1'b1;
            if (r_cnt == CW'(1)) w_state_nxt = S_RESP;
         end
         S_RESP: begin
            busy        = 1'b1;
            done        = 1'b1;
            err         = r_err;
            w_state_nxt = S_IDLE;
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_cnt   <= '0;
         r_rd    <= 1'b0;
         r_wr    <= 1'b0;
         r_err   <= 1'b0;
         r_size  <= '0;
         r_addr  <= '0;
         r_wdata <= '0;
         r_rdata <= '0;
      end else if (w_accept) begin
         r_rd    <= MemRead;
         r_wr    <= MemWrite;
         r_size  <= XferSize;
         r_addr  <= address;
         r_wdata <= WriteData;
         r_cnt   <= c_cnt_init;
         r_err   <= 1'b0;
      end else if (r_state == S_WAIT) begin
         r_cnt <= r_cnt - CW'(1);
         if (w_fire) begin
            r_err <= w_reject;
            if (r_rd && !w_reject) r_rdata <= w_rdata;
         end
      end
   end

   assign ReadData = r_rdata;

endmodule
`default_nettype wire

// File: tb/tb_data_mem_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_data_mem_ctrl
// Brief    : Randomized self-checking bench for data_mem_ctrl with byte-array model.
// Revision : 1.0
// ============================================================================
module tb_data_mem_ctrl;

   localparam int DEPTH   = 1024;
   localparam int LATENCY = 2;

   logic        clk;
   logic        reset;
   logic        MemRead;
   logic        MemWrite;
   logic [3:0]  XferSize;
   logic [63:0] address;
   logic [63:0] WriteData;
   logic [63:0] ReadData;
   logic        busy;
   logic        done;
   logic        err;

   int          n_checks;
   int          n_pass;
   logic [7:0]  mem_m [DEPTH];
   logic [63:0] m_rdata;

   data_mem_ctrl #(.DEPTH(DEPTH), .LATENCY(LATENCY)) dut (
      .clk       (clk),
      .reset     (reset),
      .MemRead   (MemRead),
      .MemWrite  (MemWrite),
      .XferSize  (XferSize),
      .address   (address),
      .WriteData (WriteData),
      .ReadData  (ReadData),
      .busy      (busy),
      .done      (done),
      .err       (err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", tag, got, exp);
   endtask

   // Returns 1 when the access must be rejected; otherwise applies it to the model.
   function automatic bit model_access(bit rd, bit wr, logic [3:0] sz, logic [63:0] ad,
                                       logic [63:0] wd);
      longint unsigned a = ad;
      longint unsigned s = 64'(sz);
      logic [63:0]     v = '0;
      if (rd && wr) return 1'b1;
      if (!(s == 1 || s == 2 || s == 4 || s == 8)) return 1'b1;
      if (a % s != 0) return 1'b1;
      if (a > DEPTH || (64'(DEPTH) - a) < s) return 1'b1;
      for (int i = 0; i < int'(s); i++) begin
         if (wr) mem_m[a + 64'(i)] = wd[8*(int'(s)-1-i) +: 8];
         else    v = (v << 8) | 64'(mem_m[a + 64'(i)]);
      end
      if (rd) m_rdata = v;
      return 1'b0;
   endfunction

   task automatic scramble();
      address   = {$urandom, $urandom};
      WriteData = {$urandom, $urandom};
      XferSize  = 4'($urandom);
   endtask

   // Entered one time unit after an edge with the DUT idle; leaves it the same way.
   task automatic do_access(input bit rd, input bit wr, input logic [3:0] sz,
                            input logic [63:0] ad, input logic [63:0] wd, input string tag);
      int n;
      bit exp_err;
      MemRead = rd; MemWrite = wr; XferSize = sz; address = ad; WriteData = wd;
      @(posedge clk); #1;
      check({tag, ":busy"}, 64'(busy), 64'd1);
      exp_err = model_access(rd, wr, sz, ad, wd);
      scramble();
      n = 0;
      while (!done && n < 20) begin
         @(posedge clk); #1;
         n++;
         if (!done) scramble();
      end
      check({tag, ":latency"}, 64'(n), 64'(LATENCY));
      check({tag, ":err"}, 64'(err), 64'(exp_err));
      check({tag, ":rdata"}, ReadData, m_rdata);
      MemRead = 1'b0; MemWrite = 1'b0;
      @(posedge clk); #1;
      check({tag, ":idle"}, {62'd0, busy, done}, 64'd0);
   endtask

   initial begin
      int          pulses, cyc, t_last, k, sel;
      logic [3:0]  sz;
      logic [63:0] ad;
      logic [3:0]  sizes [10] = '{4'd1, 4'd2, 4'd4, 4'd8, 4'd1, 4'd2, 4'd4, 4'd8, 4'd3, 4'd0};
      bit          rd, wr;
      longint unsigned stride;

      n_checks = 0; n_pass = 0; m_rdata = '0;
      reset = 1'b0; MemRead = 1'b0; MemWrite = 1'b0;
      XferSize = '0; address = '0; WriteData = '0;
      #12;
      check("reset:outs", {61'd0, busy, done, err}, 64'd0);
      check("reset:rdata", ReadData, 64'd0);
      reset = 1'b1;
      @(posedge clk); #1;

      for (int a = 0; a < DEPTH; a += 8)
         do_access(1'b0, 1'b1, 4'd8, 64'(a), {$urandom, $urandom}, "init");

      // Write aborted by reset during WAIT must leave RAM untouched.
      MemWrite = 1'b1; XferSize = 4'd1; address = 64'h10; WriteData = 64'hAA;
      @(posedge clk); #1;
      #2 reset = 1'b0;
      MemWrite = 1'b0;
      #1;
      check("t1:reset_outs", {62'd0, busy, done}, 64'd0);
      check("t1:reset_rdata", ReadData, 64'd0);
      m_rdata = '0;
      #2 reset = 1'b1;
      @(posedge clk); #1;
      check("t1:still_idle", 64'(busy), 64'd0);
      do_access(1'b1, 1'b0, 4'd8, 64'h10, '0, "t1:read");

      do_access(1'b0, 1'b1, 4'd8, 64'h0, 64'h0123456789ABCDEF, "t2:write");
      do_access(1'b1, 1'b0, 4'd1, 64'h0, '0, "t2:ram0");
      check("t2:ram0_const", ReadData, 64'h01);
      do_access(1'b1, 1'b0, 4'd2, 64'h2, '0, "t3:rd2");
      check("t3:rd2_const", ReadData, 64'h4567);
      do_access(1'b1, 1'b0, 4'd1, 64'h7, '0, "t3:rd1");
      check("t3:rd1_const", ReadData, 64'hEF);

      do_access(1'b1, 1'b0, 4'd4, 64'h6, '0, "t4:misalign");
      check("t4:held", ReadData, 64'hEF);
      do_access(1'b1, 1'b0, 4'd8, 64'(DEPTH - 4), '0, "t4:over_end");
      do_access(1'b1, 1'b0, 4'd3, 64'h0, '0, "t4:size3");
      do_access(1'b1, 1'b0, 4'd8, 64'(DEPTH - 8), '0, "t4:last_ok");
      do_access(1'b1, 1'b0, 4'd8, 64'hFFFF_FFFF_FFFF_FFF8, '0, "t4:wrap");

      do_access(1'b1, 1'b1, 4'd8, 64'h8, 64'h1111_2222_3333_4444, "t5:both");
      do_access(1'b1, 1'b0, 4'd8, 64'h8, '0, "t5:readback");

      // Held read request: one access every LATENCY+2 cycles, busy-time noise ignored.
      MemRead = 1'b1; MemWrite = 1'b0; XferSize = 4'd8; address = '0;
      void'(model_access(1'b1, 1'b0, 4'd8, 64'h0, '0));
      pulses = 0; cyc = 0; t_last = 0;
      while (pulses < 4 && cyc < 100) begin
         @(posedge clk); #1;
         cyc++;
         if (done) begin
            check("t6:err", 64'(err), 64'd0);
            check("t6:rdata", ReadData, m_rdata);
            if (pulses > 0) check("t6:period", 64'(cyc - t_last), 64'(LATENCY + 2));
            t_last = cyc;
            pulses++;
         end
         if (busy) begin
            scramble();
            MemWrite = 1'($urandom);
         end else begin
            MemWrite = 1'b0; XferSize = 4'd8; address = '0;
         end
      end
      check("t6:pulses", 64'(pulses), 64'd4);
      MemRead = 1'b0; MemWrite = 1'b0;
      k = 0;
      while (busy && k < 20) begin
         @(posedge clk); #1;
         k++;
      end
      check("t6:drain", 64'(busy), 64'd0);

      for (int t = 0; t < 300; t++) begin
         sz     = sizes[$urandom_range(0, 9)];
         stride = (sz == 1 || sz == 2 || sz == 4 || sz == 8) ? 64'(sz) : 64'd1;
         sel    = $urandom_range(0, 9);
         if (sel <= 6)      ad = 64'($urandom_range(0, DEPTH - 1)) / stride * stride;
         else if (sel == 7) ad = 64'($urandom_range(0, DEPTH - 1));
         else if (sel == 8) ad = 64'(DEPTH) - 64'($urandom_range(0, 16));
         else               ad = {$urandom, $urandom};
         k  = $urandom_range(0, 15);
         rd = (k == 0) || !k[0];
         wr = (k == 0) || k[0];
         do_access(rd, wr, sz, ad, {$urandom, $urandom}, "rand");
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
`default_nettype wire
